hood_gear_controller: RTL and testbench

- Parametrised operating-mode controller for the range-hood product; successor to the fixed three-gear mode logic.
- Consumes debounced single-cycle key pulses and a 1 s tick. Produces power state, gear number, self-clean status, light, countdown value for the seven-segment driver, clean-reminder flag and beep.
- Adds over the previous generation:
  - N gears.
  - Top-gear time limit with once-per-session lockout.
  - Self-clean countdown with completion beep.
  - Saturating accumulated-work counter driving the clean reminder.

---
 rtl/hood_gear_controller.sv | 210 +++++++++++++++++++++
 tb/tb_hood_gear_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hood_gear_controller.sv
// hood_gear_controller
// Operating-mode controller for the range hood: power, N fan gears, a time-limited
// top gear (once per power session), a timed self-clean with completion beep, and
// a saturating work accumulator that raises a clean reminder.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   sec_tick        - one-cycle pulse once per second
//   power_key       - toggles power
//   up_key/down_key - gear up / gear down
//   clean_key       - start self-clean from standby
//   light_key       - toggle light (any non-OFF state)
//   power_on        - 1 when not OFF
//   gear            - current gear, 0 in OFF/STANDBY/CLEAN
//   cleaning        - 1 in CLEAN
//   top_locked      - top gear already used this power session
//   light           - light state
//   clean_reminder  - accumulated work reached REMIND_S
//   remain_s        - countdown in TOP or CLEAN, else 0
//   beep            - completion beep
module hood_gear_controller #(
    parameter int unsigned N_GEARS     = 3,
    parameter int unsigned TOP_LIMIT_S = 60,
    parameter int unsigned CLEAN_S     = 180,
    parameter int unsigned REMIND_S    = 36000,
    parameter int unsigned BEEP_S      = 3,
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned WORK_W      = 24
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sec_tick,
    input  logic                               power_key,
    input  logic                               up_key,
    input  logic                               down_key,
    input  logic                               clean_key,
    input  logic                               light_key,
    output logic                               power_on,
    output logic [$clog2(N_GEARS+1)-1:0]       gear,
    output logic                               cleaning,
    output logic                               top_locked,
    output logic                               light,
    output logic                               clean_reminder,
    output logic [TIME_W-1:0]                  remain_s,
    output logic                               beep
);

    localparam int unsigned GEAR_W = $clog2(N_GEARS + 1);
    localparam int unsigned BEEP_W = (BEEP_S < 2) ? 1 : $clog2(BEEP_S + 1);

    localparam logic [GEAR_W-1:0] TOP_GEAR  = GEAR_W'(N_GEARS);
    localparam logic [GEAR_W-1:0] SUB_GEAR  = GEAR_W'(N_GEARS - 1);
    localparam logic [WORK_W-1:0] WORK_MAX  = {WORK_W{1'b1}};

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STANDBY,
        ST_GEAR,
        ST_TOP,
        ST_CLEAN
    } state_t;

    state_t              state_q, state_d;
    logic [GEAR_W-1:0]   gear_d;
    logic [TIME_W-1:0]   remain_d;
    logic                locked_d;
    logic                light_d;
    logic                beep_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            gear           <= '0;
            remain_s       <= '0;
            top_locked     <= 1'b0;
            light          <= 1'b0;
            beep           <= 1'b0;
            beep_cnt_q     <= '0;
            work_q         <= '0;
            power_on       <= 1'b0;
            cleaning       <= 1'b0;
            clean_reminder <= 1'b0;
        end else begin
            state_q        <= state_d;
            gear           <= gear_d;
            remain_s       <= remain_d;
            top_locked     <= locked_d;
            light          <= light_d;
            beep           <= beep_d;
            beep_cnt_q     <= beep_cnt_d;
            work_q         <= work_d;
            power_on       <= (state_d != ST_OFF);
            cleaning       <= (state_d == ST_CLEAN);
            clean_reminder <= (work_d >= WORK_W'(REMIND_S));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        gear_d     = gear;
        remain_d   = remain_s;
        locked_d   = top_locked;
        light_d    = light;
        beep_d     = beep;
        beep_cnt_d = beep_cnt_q;
        work_d     = work_q;

        // Work counts the tick against the gear held before any transition
        if (sec_tick && (gear != '0) && (work_q != WORK_MAX)) begin
            work_d = work_q + WORK_W'(1);
        end

        if (beep && sec_tick) begin
            if (beep_cnt_q <= BEEP_W'(1)) begin
                beep_d     = 1'b0;
                beep_cnt_d = '0;
            end else begin
                beep_cnt_d = beep_cnt_q - BEEP_W'(1);
            end
        end

        if ((state_q != ST_OFF) && light_key) begin
            light_d = ~light;
        end

        // Keys are taken in priority order; a key that has no effect in the
        // current state lets the next one through. Any key transition suppresses
        // the tick on the timer.
        case (state_q)
            ST_OFF: begin
                if (power_key) begin
                    state_d = ST_STANDBY;
                end
            end
            ST_STANDBY: begin
                if (clean_key) begin
                    state_d  = ST_CLEAN;
                    remain_d = TIME_W'(CLEAN_S);
                end else if (up_key) begin
                    state_d = ST_GEAR;
                    gear_d  = GEAR_W'(1);
                end
            end
            ST_GEAR: begin
                if (up_key && (gear < SUB_GEAR)) begin
                    gear_d = gear + GEAR_W'(1);
                end else if (up_key && !top_locked) begin
                    state_d  = ST_TOP;
                    gear_d   = TOP_GEAR;
                    remain_d = TIME_W'(TOP_LIMIT_S);
                    locked_d = 1'b1;
                end else if (down_key) begin
                    if (gear == GEAR_W'(1)) begin
                        state_d = ST_STANDBY;
                        gear_d  = '0;
                    end else begin
                        gear_d = gear - GEAR_W'(1);
                    end
                end
            end
            ST_TOP: begin
                if (down_key) begin
                    state_d  = ST_GEAR;
                    gear_d   = SUB_GEAR;
                    remain_d = '0;
                end else if (sec_tick) begin
                    if (remain_s <= TIME_W'(1)) begin
                        state_d  = ST_GEAR;
                        gear_d   = SUB_GEAR;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_s - TIME_W'(1);
                    end
                end
            end
            ST_CLEAN: begin
                if (sec_tick) begin
                    if (remain_s <= TIME_W'(1)) begin
                        state_d    = ST_STANDBY;
                        remain_d   = '0;
                        work_d     = '0;
                        beep_d     = 1'b1;
                        beep_cnt_d = BEEP_W'(BEEP_S);
                    end else begin
                        remain_d = remain_s - TIME_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Power-off overrides everything except the work history
        if ((state_q != ST_OFF) && power_key) begin
            state_d    = ST_OFF;
            gear_d     = '0;
            remain_d   = '0;
            locked_d   = 1'b0;
            light_d    = 1'b0;
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_hood_gear_controller.sv
// Directed bench for hood_gear_controller with small parameters
// (N_GEARS=3, TOP_LIMIT_S=5, CLEAN_S=4, REMIND_S=10, BEEP_S=2).
module tb_hood_gear_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sec_tick = 1'b0;
    logic        power_key = 1'b0;
    logic        up_key = 1'b0;
    logic        down_key = 1'b0;
    logic        clean_key = 1'b0;
    logic        light_key = 1'b0;
    logic        power_on;
    logic [1:0]  gear;
    logic        cleaning;
    logic        top_locked;
    logic        light;
    logic        clean_reminder;
    logic [15:0] remain_s;
    logic        beep;

    int n_cmp = 0;
    int n_err = 0;

    hood_gear_controller #(
        .N_GEARS    (3),
        .TOP_LIMIT_S(5),
        .CLEAN_S    (4),
        .REMIND_S   (10),
        .BEEP_S     (2),
        .TIME_W     (16),
        .WORK_W     (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sec_tick      (sec_tick),
        .power_key     (power_key),
        .up_key        (up_key),
        .down_key      (down_key),
        .clean_key     (clean_key),
        .light_key     (light_key),
        .power_on      (power_on),
        .gear          (gear),
        .cleaning      (cleaning),
        .top_locked    (top_locked),
        .light         (light),
        .clean_reminder(clean_reminder),
        .remain_s      (remain_s),
        .beep          (beep)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic pk, input logic uk, input logic dk,
                        input logic ck, input logic lk, input logic tk);
        power_key = pk; up_key = uk; down_key = dk;
        clean_key = ck; light_key = lk; sec_tick = tk;
        @(posedge clk);
        #1;
        power_key = 1'b0; up_key = 1'b0; down_key = 1'b0;
        clean_key = 1'b0; light_key = 1'b0; sec_tick = 1'b0;
    endtask

    // Compare the whole output vector {power_on,gear,cleaning,top_locked,light,reminder,beep,remain_s}
    task automatic expect_st(input string tag, input logic p, input logic [1:0] g,
                             input logic c, input logic tl, input logic l,
                             input logic r, input logic b, input logic [15:0] rem);
        logic [23:0] obs;
        logic [23:0] exp_v;
        obs   = {power_on, gear, cleaning, top_locked, light, clean_reminder, beep, remain_s};
        exp_v = {p, g, c, tl, l, r, b, rem};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset
        #3;
        expect_st("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // OFF ignores everything but power
        step(0, 1, 0, 1, 1, 1);
        expect_st("off_ignore", 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_st("power_on", 1, 0, 0, 0, 0, 0, 0, 0);

        // Gear stepping
        step(0, 0, 1, 0, 0, 0);
        expect_st("standby_down", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("up_g1", 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("up_g2", 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("up_top", 1, 3, 0, 1, 0, 0, 0, 5);
        step(0, 0, 1, 0, 0, 0);
        expect_st("top_down", 1, 2, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("top_locked_up", 1, 2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_st("down_g1", 1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_st("down_standby", 1, 0, 0, 1, 0, 0, 0, 0);

        // Top-gear time limit (work_s counts 5 ticks here)
        step(1, 0, 0, 0, 0, 0);
        expect_st("off1", 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("top_again", 1, 3, 0, 1, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 1);
        expect_st("top_t4", 1, 3, 0, 1, 0, 0, 0, 4);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        expect_st("top_t2", 1, 3, 0, 1, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 1);
        expect_st("top_t1", 1, 3, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        expect_st("top_expire", 1, 2, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_st("relock_clear", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_st("top_reach", 1, 3, 0, 1, 0, 0, 0, 5);
        step(0, 0, 0, 0, 1, 0);
        expect_st("light_on", 1, 3, 0, 1, 1, 0, 0, 5);
        // Power with tick in TOP (work_s -> 6)
        step(1, 0, 0, 0, 0, 1);
        expect_st("top_power_tick", 0, 0, 0, 0, 0, 0, 0, 0);

        // Up and down together in GEAR(2) -> TOP
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        expect_st("up_down_top", 1, 3, 0, 1, 0, 0, 0, 5);
        // Down with tick: key wins, work_s -> 7
        step(0, 0, 1, 0, 0, 1);
        expect_st("down_tick", 1, 2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_st("back_standby", 1, 0, 0, 1, 0, 0, 0, 0);

        // Self-clean and beep
        step(0, 0, 0, 1, 0, 0);
        expect_st("clean_start", 1, 0, 1, 1, 0, 0, 0, 4);
        step(0, 1, 0, 0, 0, 1);
        expect_st("clean_t3_up_ign", 1, 0, 1, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        expect_st("clean_t1", 1, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        expect_st("clean_done", 1, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        expect_st("beep_hold", 1, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        expect_st("beep_clear", 1, 0, 0, 1, 0, 0, 0, 0);

        // Reminder after 10 gear seconds
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
        expect_st("remind_9", 1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        expect_st("remind_10", 1, 1, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_st("remind_off", 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_st("remind_on", 1, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        expect_st("remind_cleared", 1, 0, 0, 0, 0, 0, 1, 0);
        // work_s restarted from 0: 9 ticks must not remind
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
        expect_st("work_reset", 1, 1, 0, 0, 0, 0, 0, 0);

        // Async reset mid-clean
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        expect_st("clean_rem2", 1, 0, 1, 0, 0, 0, 0, 2);
        rst_n = 1'b0;
        #2;
        expect_st("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 1, 0, 1, 1, 1);
        expect_st("post_reset_ign", 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_st("post_reset_on", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
